pes_rca_seq: RTL and testbench
==============================

Name: pes_rca_seq

Overview:
- Parametrised, multi-cycle ripple-carry adder/subtractor. Successor to the fixed 4-bit combinational RCA.
- Processes a WIDTH-bit operation CHUNK bits per clock, least-significant chunk first, and ripples the carry between cycles through a register.
- Uses a valid/ready handshake on both sides. Supplies carry-in, subtract mode, carry-out and signed overflow.
- Used where a wide add must fit a short combinational path at the cost of latency.

Parameters:
- WIDTH, 16, operand and result width in bits; must be at least 1.
- CHUNK, 4, bits added per cycle; must be at least 1, and WIDTH % CHUNK must be 0. An illegal combination is an elaboration error.
- N (localparam), WIDTH/CHUNK, number of RUN cycles per operation.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept an operation; equals (state==IDLE)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) or borrow-in (sub)
- sub  in  1  0 = a+b+cin; 1 = a-b-cin
- out_valid  out  1  result valid; equals (state==DONE)
- out_ready  in  1  consumer accepts the result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  carry out of the MSB; in sub mode 1 means no borrow
- ovf  out  1  two's-complement overflow

Behaviour:
- Reset and polarity: one clock, clk; reset rst is asynchronous, active-high.
- While rst=1:
  - state=IDLE, chunk counter=0, carry reg=0, operand regs=0
  - sum=0, cout=0, ovf=0, out_valid=0, in_ready=1
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Accept on in_valid && in_ready at edge E0.
  - Capture a_r=a and b_r = sub ? ~b : b.
  - Set carry = cin ^ sub, so sub with cin=0 gives a-b and sub with cin=1 gives a-b-1.
  - Clear the counter and go to RUN.
- RUN:
  - Each edge adds a_r[CHUNK-1:0] + b_r[CHUNK-1:0] + carry.
  - The CHUNK-bit result is written into the sum register at chunk position k; the carry register takes the chunk carry-out.
  - a_r and b_r shift right by CHUNK; k increments.
  - On the edge where k==N-1: latch cout = final carry and ovf = (carry into bit WIDTH-1) ^ (carry out of bit WIDTH-1), then go to DONE.
- Latency and throughput:
  - out_valid rises after edge E0+N, i.e. N cycles after acceptance.
  - Minimum initiation interval is N+2 cycles (accept, N RUN cycles, DONE, IDLE).
- DONE:
  - sum, cout and ovf are held stable while out_valid && !out_ready.
  - On out_valid && out_ready go to IDLE; in_ready=1 from the next cycle.
  - sum, cout and ovf keep their last value until the next operation completes.
- in_ready is 0 in RUN and DONE. in_valid, a, b, cin and sub are ignored there; operands captured at E0 are used throughout.
- sum is only architecturally valid while out_valid=1. Partial values during RUN carry no meaning.
- CHUNK==WIDTH (N=1): one RUN cycle, latency 1, behaviour otherwise identical.
- Reset asserted mid-RUN or mid-DONE aborts the operation, and out_valid never asserts for it. The next accepted operation is computed from clean state.
- Carry chain: the full ripple crosses chunk boundaries via the carry register only; no combinational path spans more than CHUNK bits plus mux and flop.
- No X propagation: unused states decode to IDLE.

Test Plan:
- WIDTH=16, CHUNK=4: reset, then a=0x1234 b=0x4321 cin=0 sub=0 -> out_valid exactly 4 cycles after accept, sum=0x5555, cout=0, ovf=0.
- a=0xFFFF b=0x0001 cin=0 add -> sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 chunks). a=0x7FFF b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract mode:
  - a=0x0005 b=0x0007 sub=1 cin=0 -> sum=0xFFFE, cout=0, ovf=0.
  - a=0x8000 b=0x0001 sub=1 -> sum=0x7FFF, cout=1, ovf=1.
  - a=0x0010 b=0x0001 sub=1 cin=1 -> sum=0x000E, cout=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid while toggling in_valid/a/b -> sum/cout/ovf stable, in_ready=0, no new capture. Then out_ready=1 -> out_valid=0 and in_ready=1 the next cycle.
- Assert rst 2 cycles into RUN -> out_valid, sum, cout and ovf all 0 at once, in_ready=1. Then a=0x0001 b=0x0002 -> sum=0x0003 after 4 cycles.
- WIDTH=16, CHUNK=16: a=0xFFFF b=0xFFFF cin=1 -> out_valid 1 cycle after accept, sum=0xFFFF, cout=1, ovf=0. Random compare against a+b+cin / a-b-cin for 1000 vectors with random out_ready.

Source files
------------

// File: rtl/pes_rca_seq.sv
// Multi-cycle ripple-carry adder/subtractor: WIDTH bits added CHUNK bits per clock, LS chunk first.
// Latency N=WIDTH/CHUNK cycles after accept; results held in DONE until out_ready.
module pes_rca_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("pes_rca_seq: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK:0]   chunk_res;
  logic             msb_cin;
  logic [WIDTH-1:0] acc_ins;

  // Only one CHUNK-wide adder; the ripple between chunks goes through carry_q.
  assign chunk_res = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
  // Carry into the top bit of the chunk, recovered from its sum bit.
  assign msb_cin   = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_res[CHUNK-1];

  always_comb begin
    acc_ins = acc_q;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) acc_ins[i*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_ins;
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = chunk_res[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          sum_d   = acc_ins;
          cout_d  = chunk_res[CHUNK];
          ovf_d   = msb_cin ^ chunk_res[CHUNK];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pes_rca_seq.sv
// Bench for pes_rca_seq: CHUNK=4 and CHUNK=16 instances, scoreboard queues fed by the driver,
// a negedge monitor compares results, latency and handshake behaviour.
module tb_pes_rca_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid [2];
  logic         in_ready [2];
  logic         cin      [2];
  logic         sub      [2];
  logic         out_valid[2];
  logic         out_ready[2];
  logic         cout     [2];
  logic         ovf      [2];
  logic [W-1:0] a        [2];
  logic [W-1:0] b        [2];
  logic [W-1:0] sum      [2];

  pes_rca_seq #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .cin(cin[0]), .sub(sub[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(sum[0]), .cout(cout[0]), .ovf(ovf[0])
  );

  pes_rca_seq #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .cin(cin[1]), .sub(sub[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(sum[1]), .cout(cout[1]), .ovf(ovf[1])
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   rnd_mode = 1'b0;
  logic prev_ov[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s);
    exp_t e;
    int   ui;
    int   si;
    if (!s) begin
      ui  = int'(x) + int'(y) + int'(c);
      si  = int'($signed(x)) + int'($signed(y)) + int'(c);
      e.c = (ui > 65535);
    end else begin
      ui  = int'(x) - int'(y) - int'(c);
      si  = int'($signed(x)) - int'($signed(y)) - int'(c);
      e.c = (ui >= 0);
    end
    e.s   = ui[15:0];
    e.o   = (si > 32767) || (si < -32768);
    e.acc = 0;
    return e;
  endfunction

  // Monitor: compare against the head of the queue every cycle out_valid is high.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    for (int d = 0; d < 2; d++) begin
      if (!rst && out_valid[d]) begin
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (!have) begin
          chk(d == 0 ? "c4_unexpected_out_valid" : "c16_unexpected_out_valid", {31'd0, out_valid[d]}, 32'd0);
        end else begin
          if (d == 0) e = q0[0];
          else        e = q1[0];
          if (!prev_ov[d]) chk(d == 0 ? "c4_latency" : "c16_latency", cyc - e.acc, (d == 0) ? 4 : 1);
          chk(d == 0 ? "c4_sum"  : "c16_sum",  {16'd0, sum[d]}, {16'd0, e.s});
          chk(d == 0 ? "c4_cout" : "c16_cout", {31'd0, cout[d]}, {31'd0, e.c});
          chk(d == 0 ? "c4_ovf"  : "c16_ovf",  {31'd0, ovf[d]},  {31'd0, e.o});
          chk(d == 0 ? "c4_in_ready_busy" : "c16_in_ready_busy", {31'd0, in_ready[d]}, 32'd0);
          if (out_ready[d]) begin
            if (d == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
          end
        end
      end
      prev_ov[d] = out_valid[d];
    end
  end

  always @(posedge clk) begin
    if (rnd_mode) begin
      #1;
      out_ready[0] = 1'($urandom_range(1));
      out_ready[1] = 1'($urandom_range(1));
    end
  end

  // Call at posedge+#1; returns at posedge+#1 just after the accepting edge.
  task automatic issue_e(input int d, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input logic is, input exp_t e_in);
    exp_t e;
    int   n = 0;
    e = e_in;
    in_valid[d] = 1'b1; a[d] = ia; b[d] = ib; cin[d] = ic; sub[d] = is;
    while (!in_ready[d] && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready[d]) begin
      chk("accept_timeout", {31'd0, in_ready[d]}, 32'd1);
      in_valid[d] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    a[d] = W'($urandom); b[d] = W'($urandom); cin[d] = 1'($urandom); sub[d] = 1'($urandom);
    e.acc = cyc;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic issue(input int d, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic is,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    e.s = es; e.c = ec; e.o = eo; e.acc = 0;
    issue_e(d, ia, ib, ic, is, e);
  endtask

  task automatic drain(input int d);
    int n = 0;
    while (((d == 0) ? q0.size() : q1.size()) > 0 && n < 500) begin
      @(posedge clk); #1; n++;
    end
    chk(d == 0 ? "c4_drain" : "c16_drain", (d == 0) ? q0.size() : q1.size(), 0);
  endtask

  task automatic rnd_run(input int d, input int count);
    logic [W-1:0] x, y;
    logic         c, s;
    for (int i = 0; i < count; i++) begin
      x = W'($urandom); y = W'($urandom); c = 1'($urandom); s = 1'($urandom);
      issue_e(d, x, y, c, s, model(x, y, c, s));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; a[d] = '0; b[d] = '0; cin[d] = 1'b0; sub[d] = 1'b0;
      out_ready[d] = 1'b1; prev_ov[d] = 1'b0;
    end
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_valid", {31'd0, out_valid[d]}, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready[d]},  32'd1);
      chk("rst_sum",       {16'd0, sum[d]},       32'd0);
      chk("rst_cout",      {31'd0, cout[d]},      32'd0);
      chk("rst_ovf",       {31'd0, ovf[d]},       32'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    issue(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    issue(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    issue(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    issue(0, 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);
    drain(0);

    // Backpressure: hold the result while inputs wiggle.
    out_ready[0] = 1'b0;
    issue(0, 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    n = 0;
    while (!out_valid[0] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_out_valid", {31'd0, out_valid[0]}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      in_valid[0] = ~in_valid[0]; a[0] = W'($urandom); b[0] = W'($urandom);
      @(posedge clk); #1;
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", {31'd0, out_valid[0]}, 32'd0);
    chk("bp_release_in_ready",  {31'd0, in_ready[0]},  32'd1);
    chk("bp_no_extra_capture",  q0.size(), 0);

    // Leave a nonzero result behind, then reset two cycles into the next RUN.
    issue(0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    drain(0);
    issue(0, 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrun_rst_out_valid", {31'd0, out_valid[0]}, 32'd0);
    chk("midrun_rst_sum",       {16'd0, sum[0]},       32'd0);
    chk("midrun_rst_cout",      {31'd0, cout[0]},      32'd0);
    chk("midrun_rst_ovf",       {31'd0, ovf[0]},       32'd0);
    chk("midrun_rst_in_ready",  {31'd0, in_ready[0]},  32'd1);
    q0.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(0, 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
    drain(0);

    issue(1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    issue(1, 16'h8000, 16'h7FFF, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1);
    drain(1);

    rnd_mode = 1'b1;
    fork
      rnd_run(1, 1000);
      rnd_run(0, 200);
    join
    rnd_mode = 1'b0;
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    drain(0);
    drain(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
